utopia1_phy_rx_tx: RTL

//  PHY-side transmitter of the Utopia level 1 Rx interface (cell-level handshake).

---
 rtl/utopia_pkg.sv | 18 +
 rtl/utopia_cell_ram.sv | 41 ++++
 rtl/utopia1_phy_rx_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/utopia_pkg.sv
// Shared constants and types for the Utopia level 1 PHY Rx-side transmitter.
package utopia_pkg;

  localparam int CELL_BYTES = 53;

  // Byte position within a cell, 0..52.
  typedef logic [5:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(CELL_BYTES - 1);

  // Read-side transfer state toward the ATM layer.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/utopia_cell_ram.sv
// Cell buffer: DEPTH whole cells of 53 bytes, one write port, one registered read port.
module utopia_cell_ram
  import utopia_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = $clog2(DEPTH * CELL_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH * CELL_BYTES];
  logic [7:0] rd_data_q, rd_data_d;

  // Byte storage write port.
  // NOTE: the storage array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register loads only when a new byte is launched, so a paused transfer holds its byte.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Output register doubles as the Utopia data line.
  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= 8'h00;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/utopia1_phy_rx_tx.sv
// PHY-side Utopia level 1 Rx transmitter: buffers whole cells, sends them under en.
module utopia1_phy_rx_tx
  import utopia_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_soc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       data,
  output logic             soc,
  input  logic             en,
  output logic             clav,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH * CELL_BYTES);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);

  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PTR_W-1:0] slot,
                                                  input byte_idx_t idx);
    return ADDR_W'(slot) * ADDR_W'(CELL_BYTES) + ADDR_W'(idx);
  endfunction

  byte_idx_t         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic              wr_active_q, wr_active_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  rd_state_e         state_q, state_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              soc_q, soc_d, clav_q, clav_d, in_ready_q, in_ready_d;
  logic              wr_en, rd_en, commit, free;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Write side: cell framing on in_soc, runt detection, commit after byte 53.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_active_d = wr_active_q;
    wr_ptr_d    = wr_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = slot_addr(wr_ptr_q, wr_idx_q);
    commit      = 1'b0;
    if (in_valid && in_ready_q) begin
      if (in_soc) begin
        // A new start while a cell is open abandons the partial cell.
        if (wr_active_q && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        wr_en       = 1'b1;
        wr_addr     = slot_addr(wr_ptr_q, '0);
        wr_idx_d    = byte_idx_t'(1);
        wr_active_d = 1'b1;
      end else if (wr_active_q) begin
        wr_en = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          commit      = 1'b1;
          wr_active_d = 1'b0;
          wr_idx_d    = '0;
          wr_ptr_d    = next_slot(wr_ptr_q);
        end else begin
          wr_idx_d = wr_idx_q + byte_idx_t'(1);
        end
      end
    end
  end

  // Read FSM: launch byte 1 with soc, step on en low, hold on en high, free slot in DONE.
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    rd_ptr_d = rd_ptr_q;
    soc_d    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = slot_addr(rd_ptr_q, rd_idx_q);
    free     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!en && occ_q != '0) begin
          rd_en    = 1'b1;
          rd_addr  = slot_addr(rd_ptr_q, '0);
          soc_d    = 1'b1;
          rd_idx_d = byte_idx_t'(1);
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!en) begin
          rd_en = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + byte_idx_t'(1);
          end
        end
      end
      ST_DONE: begin
        free     = 1'b1;
        rd_ptr_d = next_slot(rd_ptr_q);
        state_d  = ST_IDLE;
        // Back-to-back: the next committed cell starts on the same edge the slot frees.
        if (!en && occ_q > OCC_W'(1)) begin
          rd_en    = 1'b1;
          rd_addr  = slot_addr(next_slot(rd_ptr_q), '0);
          soc_d    = 1'b1;
          rd_idx_d = byte_idx_t'(1);
          state_d  = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy and the registered flow-control outputs derived from it.
  always_comb begin
    occ_d      = occ_q + OCC_W'(commit) - OCC_W'(free);
    in_ready_d = (occ_d < FULL_OCC);
    // A cell in DONE has been fully sent and no longer counts as available.
    if (state_d == ST_DONE) clav_d = (occ_d > OCC_W'(1));
    else                    clav_d = (occ_d != '0);
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q    <= '0;
      wr_active_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      occ_q       <= '0;
      drop_cnt_q  <= '0;
      soc_q       <= 1'b0;
      clav_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_active_q <= wr_active_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_idx_q    <= rd_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      occ_q       <= occ_d;
      drop_cnt_q  <= drop_cnt_d;
      soc_q       <= soc_d;
      clav_q      <= clav_d;
      in_ready_q  <= in_ready_d;
    end
  end

  utopia_cell_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(data)
  );

  assign soc      = soc_q;
  assign clav     = clav_q;
  assign in_ready = in_ready_q;
  assign drop_cnt = drop_cnt_q;

endmodule
